// File: rtl/lut_neuron_loader.sv
// Run-time programmable truth-table neuron: a byte stream loads the table into
// distributed RAM, then registered single-cycle lookups read it back.
module lut_neuron_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic [7:0]          s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic                load_done,
    output logic                load_err,
    output logic                table_valid,
    input  logic [IN_BITS-1:0]  lut_in,
    input  logic                lut_in_valid,
    output logic [OUT_BITS-1:0] lut_out,
    output logic                lut_out_valid
);

    localparam int ENTRIES = 2 ** IN_BITS;
    localparam int TBITS   = ENTRIES * OUT_BITS;
    localparam int BEATS   = TBITS / 8;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW      = $clog2(TBITS);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] beat_cnt;
    logic [TBITS-1:0] table_bits;
    logic             beat_fire;
    logic             lookup_fire;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign s_ready     = (state == LOAD);
    assign table_valid = (state == ACTIVE);

    // A load_start in the same cycle as a handshake wins: that beat is discarded.
    assign beat_fire   = s_ready && s_valid && !load_start;
    assign lookup_fire = table_valid && lut_in_valid && !load_start;

    assign wr_idx = AW'(beat_cnt) << 3;
    assign rd_idx = AW'(lut_in) * AW'(OUT_BITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (load_start) begin
                state    <= LOAD;
                beat_cnt <= '0;
                load_err <= 1'b0;
            end else if (beat_fire) begin
                if (beat_cnt == LAST_BEAT) begin
                    beat_cnt <= '0;
                    if (s_last) begin
                        state     <= ACTIVE;
                        load_done <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        load_err <= 1'b1;
                    end
                end else if (s_last) begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                    load_err <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    // Table storage is deliberately left unreset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (beat_fire) begin
            table_bits[wr_idx +: 8] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lut_out       <= '0;
            lut_out_valid <= 1'b0;
        end else begin
            lut_out_valid <= lookup_fire;
            if (lookup_fire) begin
                lut_out <= table_bits[rd_idx +: OUT_BITS];
            end
        end
    end

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Self-checking bench for lut_neuron_loader: randomized table loads and lookups
// compared against a byte-array model of the truth table.
module tb_lut_neuron_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       load_done;
    logic       load_err;
    logic       table_valid;
    logic [7:0] lut_in;
    logic       lut_in_valid;
    logic [0:0] lut_out;
    logic       lut_out_valid;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    logic [7:0] model_beats [32];

    lut_neuron_loader #(.IN_BITS(8), .OUT_BITS(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .load_done     (load_done),
        .load_err      (load_err),
        .table_valid   (table_valid),
        .lut_in        (lut_in),
        .lut_in_valid  (lut_in_valid),
        .lut_out       (lut_out),
        .lut_out_valid (lut_out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_done === 1'b1) done_count++;
    end

    // Entry a of a 1-bit table is bit (a mod 8) of beat (a div 8).
    function automatic logic expect_bit(input int a);
        logic [7:0] b;
        b = model_beats[a / 8];
        return b[a % 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input int gap);
        s_valid = 1'b0;
        repeat (gap) step();
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic load_model(input int max_gap);
        for (int k = 0; k < 32; k++) begin
            send_beat(model_beats[k], (k == 31), int'($urandom_range(max_gap, 0)));
        end
    endtask

    task automatic randomize_model();
        for (int k = 0; k < 32; k++) model_beats[k] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; load_start = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
        lut_in = 8'h00; lut_in_valid = 1'b0;
        step();
        step();
        checks++;
        if ({s_ready, load_done, load_err, table_valid, lut_out, lut_out_valid} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b exp 000000",
                     {s_ready, load_done, load_err, table_valid, lut_out, lut_out_valid});
        end
        rst = 1'b0;
        lut_in = 8'h00;
        lut_in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (lut_out_valid !== 1'b0 || table_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_lookup got valid=%b table_valid=%b exp 0 0",
                         lut_out_valid, table_valid);
            end
        end
        lut_in_valid = 1'b0;
    endtask

    task automatic test_normal_load();
        int d0;
        logic [7:0] addrs [3];
        for (int k = 0; k < 32; k++) model_beats[k] = 8'h00;
        model_beats[0] = 8'h02;
        d0 = done_count;
        start_load();
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (s_ready !== 1'b1 || table_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL normal_streaming beat %0d got ready=%b table_valid=%b exp 1 0",
                         k, s_ready, table_valid);
            end
            send_beat(model_beats[k], (k == 31), 0);
        end
        checks++;
        if (load_done !== 1'b1 || table_valid !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL normal_complete got done=%b table_valid=%b ready=%b exp 1 1 0",
                     load_done, table_valid, s_ready);
        end
        addrs[0] = 8'h01; addrs[1] = 8'h00; addrs[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            lut_in = addrs[i];
            lut_in_valid = 1'b1;
            step();
            checks++;
            if (lut_out_valid !== 1'b1 || lut_out !== expect_bit(int'(addrs[i]))) begin
                errors++;
                $display("[TB] FAIL normal_lookup addr %h got valid=%b out=%b exp valid=1 out=%b",
                         addrs[i], lut_out_valid, lut_out, expect_bit(int'(addrs[i])));
            end
        end
        lut_in_valid = 1'b0;
        checks++;
        if (load_done !== 1'b0 || done_count - d0 !== 1) begin
            errors++;
            $display("[TB] FAIL normal_done_pulse got done=%b pulses=%0d exp 0 1",
                     load_done, done_count - d0);
        end
    endtask

    task automatic test_stalled_load();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                for (int k = 0; k < 32; k++) model_beats[k] = 8'(k);
            end else begin
                randomize_model();
            end
            start_load();
            load_model(3);
            checks++;
            if (load_done !== 1'b1 || table_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stalled_complete pass %0d got done=%b table_valid=%b exp 1 1",
                         pass, load_done, table_valid);
            end
            for (int a = 0; a < 256; a++) begin
                lut_in = 8'(a);
                lut_in_valid = 1'b1;
                step();
                checks++;
                if (lut_out_valid !== 1'b1 || lut_out !== expect_bit(a)) begin
                    errors++;
                    $display("[TB] FAIL stalled_sweep pass %0d addr %0d got valid=%b out=%b exp valid=1 out=%b",
                             pass, a, lut_out_valid, lut_out, expect_bit(a));
                end
            end
            lut_in_valid = 1'b0;
        end
    endtask

    task automatic test_framing_errors();
        randomize_model();
        for (int pass = 0; pass < 2; pass++) begin
            start_load();
            checks++;
            if (load_err !== 1'b0 || s_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL framing_start pass %0d got err=%b ready=%b exp 0 1",
                         pass, load_err, s_ready);
            end
            if (pass == 0) begin
                for (int k = 0; k <= 10; k++) send_beat(model_beats[k], (k == 10), 0);
            end else begin
                for (int k = 0; k < 32; k++) send_beat(model_beats[k], 1'b0, 0);
            end
            checks++;
            if (load_err !== 1'b1 || s_ready !== 1'b0 || table_valid !== 1'b0 || load_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL framing_error pass %0d got err=%b ready=%b table_valid=%b done=%b exp 1 0 0 0",
                         pass, load_err, s_ready, table_valid, load_done);
            end
            lut_in = 8'($urandom);
            lut_in_valid = 1'b1;
            step();
            lut_in_valid = 1'b0;
            checks++;
            if (lut_out_valid !== 1'b0 || load_err !== 1'b1) begin
                errors++;
                $display("[TB] FAIL framing_lookup pass %0d got valid=%b err=%b exp 0 1",
                         pass, lut_out_valid, load_err);
            end
        end
        start_load();
        checks++;
        if (load_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL framing_clear got err=%b exp 0", load_err);
        end
        load_model(1);
        checks++;
        if (table_valid !== 1'b1 || load_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL framing_reload got table_valid=%b err=%b exp 1 0", table_valid, load_err);
        end
    endtask

    task automatic test_restart();
        randomize_model();
        model_beats[0] = model_beats[0] | 8'h01;
        start_load();
        for (int k = 0; k < 5; k++) send_beat(8'($urandom), 1'b0, 0);
        s_data = 8'hA5;
        s_last = 1'b1;
        s_valid = 1'b1;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        checks++;
        if (s_ready !== 1'b1 || load_err !== 1'b0 || table_valid !== 1'b0 || load_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_state got ready=%b err=%b table_valid=%b done=%b exp 1 0 0 0",
                     s_ready, load_err, table_valid, load_done);
        end
        load_model(0);
        checks++;
        if (load_done !== 1'b1 || table_valid !== 1'b1 || load_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_complete got done=%b table_valid=%b err=%b exp 1 1 0",
                     load_done, table_valid, load_err);
        end
        for (int a = 0; a < 256; a++) begin
            lut_in = 8'(a);
            lut_in_valid = 1'b1;
            step();
            checks++;
            if (lut_out_valid !== 1'b1 || lut_out !== expect_bit(a)) begin
                errors++;
                $display("[TB] FAIL restart_sweep addr %0d got valid=%b out=%b exp valid=1 out=%b",
                         a, lut_out_valid, lut_out, expect_bit(a));
            end
        end
        lut_in_valid = 1'b0;
    endtask

    task automatic test_random_lookups();
        logic       req;
        logic [7:0] addr;
        logic [0:0] held;
        held = lut_out;
        for (int i = 0; i < 200; i++) begin
            req  = 1'($urandom);
            addr = 8'($urandom);
            lut_in = addr;
            lut_in_valid = req;
            step();
            if (req) held = expect_bit(int'(addr));
            checks++;
            if (lut_out_valid !== req || lut_out !== held) begin
                errors++;
                $display("[TB] FAIL random_lookup cycle %0d got valid=%b out=%b exp valid=%b out=%b",
                         i, lut_out_valid, lut_out, req, held);
            end
        end
        lut_in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        lut_in = 8'h00;
        lut_in_valid = 1'b1;
        step();
        lut_in_valid = 1'b0;
        checks++;
        if (lut_out !== 1'b1 || lut_out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_prelookup got out=%b valid=%b exp 1 1", lut_out, lut_out_valid);
        end
        randomize_model();
        start_load();
        for (int k = 0; k <= 20; k++) send_beat(model_beats[k], 1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({s_ready, load_done, load_err, table_valid, lut_out, lut_out_valid} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs got %b exp 000000",
                     {s_ready, load_done, load_err, table_valid, lut_out, lut_out_valid});
        end
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_beat(8'($urandom), 1'b1, 0);
            lut_in = 8'($urandom);
            lut_in_valid = 1'b1;
            step();
            lut_in_valid = 1'b0;
            checks++;
            if (lut_out_valid !== 1'b0 || table_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_lookup %0d got valid=%b table_valid=%b exp 0 0",
                         i, lut_out_valid, table_valid);
            end
        end
        start_load();
        load_model(2);
        for (int a = 0; a < 256; a++) begin
            lut_in = 8'(a);
            lut_in_valid = 1'b1;
            step();
            checks++;
            if (lut_out_valid !== 1'b1 || lut_out !== expect_bit(a)) begin
                errors++;
                $display("[TB] FAIL midreset_sweep addr %0d got valid=%b out=%b exp valid=1 out=%b",
                         a, lut_out_valid, lut_out, expect_bit(a));
            end
        end
        lut_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_stalled_load();
        test_framing_errors();
        test_restart();
        test_random_lookups();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lut_neuron_loader.md
# lut_neuron_loader

Run-time programmable truth-table neuron. It accepts a neuron's complete truth table as a byte stream with a valid/ready handshake and stores it in distributed RAM, then answers registered lookups with one-cycle latency. It is the writer side of the fixed ROM neurons in the per-layer LUT netlists. It sits between the configuration DMA/stream fabric and a layer's neuron inputs, so one table can be swapped in without resynthesis.

## Interface
Parameters:
- IN_BITS, 8, lookup address width; ENTRIES = 2**IN_BITS.
- OUT_BITS, 1, output bits per entry. ENTRIES*OUT_BITS must be a multiple of 8.
- BEATS is derived as ENTRIES*OUT_BITS/8, the number of stream beats per table (32 at defaults).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle pulse that begins, or restarts, a table load.
- s_data  in  8  table bits; bit i of beat k is flat table bit k*8+i.
- s_valid  in  1  beat valid.
- s_last  in  1  marks the final beat; it is only meaningful when s_valid is high.
- s_ready  out  1  high only in LOAD.
- load_done  out  1  one-cycle pulse when a load completes successfully.
- load_err  out  1  sticky framing error; cleared by load_start.
- table_valid  out  1  high only in ACTIVE.
- lut_in  in  IN_BITS  lookup address.
- lut_in_valid  in  1  lookup request.
- lut_out  out  OUT_BITS  registered lookup result.
- lut_out_valid  out  1  lookup result valid.

## Operation
- Flat table layout: entry a occupies flat bits a*OUT_BITS to a*OUT_BITS+OUT_BITS-1, LSB first.
- FSM states are IDLE, LOAD and ACTIVE. Reset enters IDLE.
- IDLE or ACTIVE, with load_start: go to LOAD, clear beat_cnt and load_err, drop table_valid.
- LOAD, on a handshake (s_valid and s_ready): write s_data to flat bits beat_cnt*8 to beat_cnt*8+7, then increment beat_cnt.
- LOAD, handshake with beat_cnt == BEATS-1 and s_last = 1: go to ACTIVE and pulse load_done.
- LOAD, handshake with beat_cnt == BEATS-1 and s_last = 0: framing error. Go to IDLE and set load_err. The stored table is undefined.
- LOAD, handshake with beat_cnt < BEATS-1 and s_last = 1: same framing error handling.
- LOAD with load_start: restart. beat_cnt returns to 0, and any beat handshaken in the same cycle is discarded.
- s_valid while not in LOAD: ignored, no write.
- Lookups are accepted only when the state is ACTIVE, lut_in_valid = 1 and load_start = 0.
- A lookup issued in any other state or condition is dropped: lut_out_valid = 0 the next cycle and lut_out holds its value.
- beat_cnt is $clog2(BEATS) bits wide and never wraps. The final beat always exits LOAD.

## Timing
- Reset values: state IDLE, beat_cnt 0, s_ready 0, load_done 0, load_err 0, table_valid 0, lut_out 0, lut_out_valid 0.
- Table RAM contents are not reset.
- s_ready rises in the cycle after load_start and falls in the cycle after the final handshake or an error.
- A stream source may hold s_valid high continuously, giving one beat per cycle.
- load_done and table_valid both rise in the cycle after the final handshake.
- load_err rises in the cycle after the offending beat.
- Lookup latency is 1 cycle: a request sampled at edge n gives lut_out and lut_out_valid after edge n+1.
- Back-to-back lookups are supported every cycle.
- A full load at defaults with no stalls takes 1 + 32 cycles from load_start to table_valid.
- Asserting rst mid-load or mid-lookup returns all outputs to their reset values immediately. No partial table is ever flagged valid.

## Test plan
- Reset, then lookup: after rst, lut_in_valid = 1 with lut_in = 8'h00 → lut_out_valid stays 0 and table_valid = 0.
- Normal load and sweep:
  - Stream 32 beats, where beat 0 = 8'h02 and all other beats are 8'h00, with s_last on beat 31 → load_done pulses once, table_valid = 1.
  - Lookup 8'h01 → lut_out = 1 one cycle later.
  - Lookups 8'h00 and 8'hFF → 0.
- Stalled stream: insert s_valid gaps of 0–3 cycles at random, with each beat k = k[7:0] → table matches the flat layout. A full 256-address sweep agrees with the model and shows no duplicate or dropped beats.
- Framing errors:
  - s_last on beat 10 → load_err = 1, state IDLE, s_ready = 0, table_valid = 0.
  - s_last = 0 on beat 31 → same result.
  - A following load_start clears load_err.
- Restart: load_start in the same cycle as the handshake of beat 5 → that beat is discarded and beat_cnt = 0. A subsequent full 32-beat load succeeds with correct contents.
- Reset mid-load: assert rst after beat 20 → all outputs return to reset values at once. Lookups give lut_out_valid = 0 until a fresh complete load.
